mmio_bus: RTL

Parametrised memory-mapped data-bus interconnect between the core's data port and NUM_SLAVES slave devices (RAM, UART, LED/GPIO, timer). Decodes each core access against per-slave base/mask windows, forwards it to exactly one slave, and waits for that slave's ready handshake. Unlike the fixed single-memory hookup, it supports variable-latency slaves, unmapped-address and timeout error responses, and a saturating error counter for debug.

---
 rtl/mmio_bus.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_bus.sv
// mmio_bus: memory-mapped interconnect from the core data port to
// NUM_SLAVES slaves. Each core access is decoded against per-slave
// base/mask windows and forwarded to one slave. The bus then waits for that
// slave's ready, or for a timeout. Unmapped addresses and requests with
// both enables high are answered with an error. Error responses are counted
// in a saturating 8-bit counter.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   mem_addr/wdata           core access address and write data
//   mem_w_enable/r_enable    core write / read request (exactly one = valid)
//   mem_rdata                registered read data, valid with mem_ready
//   mem_ready                one-cycle completion pulse
//   mem_error                qualifies mem_ready: the access failed
//   s_addr/s_wdata           broadcast address / write data (held between accesses)
//   s_w_enable/s_r_enable    per-slave write / read strobes
//   s_rdata                  packed slave read data, slave 0 in the low word
//   s_ready                  per-slave completion
//   err_count                saturating count of error responses
//   busy                     high whenever the bus is not idle
//
// state  | meaning
// IDLE   | waiting for a core request; decode happens here
// ACCESS | strobe driven to the selected slave, waiting for ready or timeout
// DONE   | one-cycle mem_ready pulse with mem_error/mem_rdata valid

module mmio_bus #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*32-1:0] BASE =
    {32'h1000_2000, 32'h1000_1000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000},
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  mem_addr,
  input  logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_w_enable,
  input  logic                         mem_r_enable,
  output logic [DATA_W-1:0]            mem_rdata,
  output logic                         mem_ready,
  output logic                         mem_error,
  output logic [31:0]                  s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [NUM_SLAVES-1:0]        s_w_enable,
  output logic [NUM_SLAVES-1:0]        s_r_enable,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [7:0]                   err_count,
  output logic                         busy
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // The wait timer is a down-counter loaded on entry to ACCESS; reaching
  // zero marks the TIMEOUT-th ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic                err_evt;

  logic                hit_any;
  logic [SEL_W-1:0]    hit_idx;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;
  logic                timeout_hit;
  logic [NUM_SLAVES-1:0] strobe;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign sel_ready   = s_ready[sel_q];
  assign sel_rdata   = s_rdata[sel_q*DATA_W +: DATA_W];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    err_evt = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_r_enable && mem_w_enable) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
          err_evt = 1'b1;
        end else if (mem_r_enable || mem_w_enable) begin
          if (hit_any) begin
            state_d = ACCESS;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            wr_d    = mem_w_enable;
            sel_d   = hit_idx;
            cnt_d   = CNT_LOAD;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
            err_evt = 1'b1;
          end
        end
      end

      ACCESS: begin
        // A ready arriving in the timeout cycle still completes normally.
        if (sel_ready) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = wr_q ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
          err_evt = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign err_count_d = (err_evt && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;

  // Strobes decode straight from registers so reset removes them at once.
  assign strobe     = (state_q == ACCESS) ? (NUM_SLAVES'(1) << sel_q) : '0;
  assign s_r_enable = wr_q ? '0 : strobe;
  assign s_w_enable = wr_q ? strobe : '0;

  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign mem_ready = (state_q == DONE);
  assign mem_error = (state_q == DONE) && err_q;
  assign mem_rdata = rdata_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != IDLE);

endmodule
